addr_seq: RTL and testbench
===========================

# addr_seq

Effective-address sequencer that borrows the shared 8-bit ALU to form 16-bit indexed addresses (absolute,X / absolute,Y / (zp),Y / zero-page,X). It accepts a base and an index from the core's decode/control logic and drives the ALU for one or two cycles: low-byte add, then a conditional high-byte increment. It returns the address plus a page-cross flag so the core can add the 6502 extra cycle. It sits between instruction control and the ALU port mux; while busy it owns the ALU.

## Interface
- No parameters; ALU opcode constants (ADD, SR, AND, OR, XOR) come from the shared params include.
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_base  in  16  base address
- req_index  in  8  unsigned index (X or Y)
- req_zp  in  1  1 = zero-page mode: result stays in page 0x00
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_addr  out  16  computed address
- resp_page_cross  out  1  low-byte add carried (full mode only)
- alu_busy  out  1  sequencer owns ALU this cycle
- alu_control  out  3  ALU opcode
- alu_AI  out  8  ALU operand A
- alu_BI  out  8  ALU operand B
- alu_carry_in  out  1  ALU carry in
- alu_Y  in  8  ALU result, combinational, same cycle
- alu_carry_out  in  1  ALU carry, combinational, same cycle

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch base, index and zp, then go to LO.
- LO: alu_busy=1, alu_control=ADD, AI=base[7:0], BI=index, cin=0. Register alu_Y into addr_lo. Carry handling by mode:
  - Zero-page: addr_hi=0x00, page_cross=0, go to DONE. The carry is discarded, so 0x00FF+0x01 gives 0x0000.
  - Full mode, carry=0: addr_hi=base[15:8], page_cross=0, go to DONE.
  - Full mode, carry=1: page_cross=1, go to HI.
- HI: alu_busy=1, ADD with AI=base[15:8], BI=0x00, cin=1. Register alu_Y into addr_hi. alu_carry_out is ignored, so 0xFFFF+0x01 wraps to 0x0000. Go to DONE.
- DONE: resp_valid=1. resp_addr and resp_page_cross stay stable until resp_ready is sampled high, then go to IDLE.
- No new request is accepted until the return to IDLE. req_ready is low in DONE even when resp_ready is high.
- When not busy: alu_control=ADD, AI=0, BI=0, cin=0. The external mux selects by alu_busy.
- ALU overflow is not used.

## Timing
- Reset, sampled low on a clk edge, takes priority over everything, including mid-LO/HI/DONE. The request in flight is dropped. Next cycle: state=IDLE, req_ready=1, resp_valid=0, resp_addr=0x0000, resp_page_cross=0, alu_busy=0, ALU outputs at idle defaults.
- Cycle numbering from the accept edge (edge 0):
  - No page cross: LO in cycle 1, resp_valid high in cycle 2 (2-cycle latency).
  - Page cross: LO in cycle 1, HI in cycle 2, resp_valid in cycle 3 (3-cycle latency).
- resp_valid falls on the edge after resp_ready is seen high in DONE. req_ready rises the same cycle.
- Minimum request spacing: 3 cycles without page cross, 4 with page cross.
- alu_busy is high in exactly the LO and HI cycles and is a registered-state decode. The ALU result path is combinational within one cycle.
- Inputs req_base, req_index and req_zp are sampled only on the accept edge. Later changes have no effect.

## Structure
- State typedef (IDLE/LO/HI/DONE, 2 bits) goes in the shared CPU package alongside the ALU opcode constants. This block redefines no opcodes.
- Single module, no sub-modules. The ALU is instantiated at the core level; this block only drives its ports.
- The bench instantiates addr_seq and the real alu, wired directly.

## Test plan
- Full mode, base=0x1234, index=0x10: LO only. resp_addr=0x1244, page_cross=0, resp_valid in cycle 2.
- Full mode, base=0x12F0, index=0x20: HI cycle taken. resp_addr=0x1310, page_cross=1, resp_valid in cycle 3, alu_busy high for exactly 2 cycles.
- Full mode, base=0xFFFF, index=0x01: resp_addr=0x0000, page_cross=1. ALU carry out of HI is ignored.
- Zero-page mode, base=0x00F0, index=0x20: resp_addr=0x0010, page_cross=0, 2-cycle latency.
- Back-pressure: resp_ready=0 for 5 cycles in DONE. resp_addr is held and req_ready stays 0. A req_valid pulse during DONE is not accepted. After resp_ready=1, IDLE follows the next cycle.
- resetn driven low during HI of a 0x12F0+0x20 request: the next cycle shows IDLE, resp_valid=0, resp_addr=0x0000, alu_busy=0. A following request, base=0x0001 with index=0x01, returns 0x0002.

Source files
------------

// File: rtl/addr_seq_pkg.sv
// Shared CPU definitions: ALU opcodes and the address-sequencer state encoding.
package addr_seq_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SR  = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   typedef logic [1:0] seq_state_t;

   localparam seq_state_t S_IDLE = 2'd0;
   localparam seq_state_t S_LO   = 2'd1;
   localparam seq_state_t S_HI   = 2'd2;
   localparam seq_state_t S_DONE = 2'd3;

endpackage

// File: rtl/alu.sv
// Shared 8-bit combinational ALU, instantiated at core level and borrowed by addr_seq.
module alu
   import addr_seq_pkg::*;
(
   input  logic [2:0] alu_control,
   input  logic [7:0] alu_AI,
   input  logic [7:0] alu_BI,
   input  logic       alu_carry_in,
   output logic [7:0] alu_Y,
   output logic       alu_carry_out
);

   always_comb begin
      alu_Y         = 8'h00;
      alu_carry_out = 1'b0;
      case (alu_control)
         ALU_ADD: {alu_carry_out, alu_Y} = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_carry_in};
         ALU_SR:  begin
            alu_Y         = {alu_carry_in, alu_AI[7:1]};
            alu_carry_out = alu_AI[0];
         end
         ALU_AND: alu_Y = alu_AI & alu_BI;
         ALU_OR:  alu_Y = alu_AI | alu_BI;
         ALU_XOR: alu_Y = alu_AI ^ alu_BI;
         default: alu_Y = 8'h00;
      endcase
   end

endmodule

// File: rtl/addr_seq.sv
// Effective-address sequencer: forms base+index via the shared ALU in one or two
// cycles (low-byte add, then high-byte increment on carry) and flags page crosses.
module addr_seq
   import addr_seq_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_base,
   input  logic [7:0]  req_index,
   input  logic        req_zp,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_addr,
   output logic        resp_page_cross,
   output logic        alu_busy,
   output logic [2:0]  alu_control,
   output logic [7:0]  alu_AI,
   output logic [7:0]  alu_BI,
   output logic        alu_carry_in,
   input  logic [7:0]  alu_Y,
   input  logic        alu_carry_out
);

   seq_state_t  state;
   logic [15:0] base_q;
   logic [7:0]  index_q;
   logic        zp_q;
   logic [7:0]  addr_lo;
   logic [7:0]  addr_hi;
   logic        page_cross;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         base_q     <= 16'h0000;
         index_q    <= 8'h00;
         zp_q       <= 1'b0;
         addr_lo    <= 8'h00;
         addr_hi    <= 8'h00;
         page_cross <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  base_q  <= req_base;
                  index_q <= req_index;
                  zp_q    <= req_zp;
                  state   <= S_LO;
               end
            end
            S_LO: begin
               addr_lo <= alu_Y;
               // zero-page wraps inside page 0, so the carry is simply dropped
               if (zp_q) begin
                  addr_hi    <= 8'h00;
                  page_cross <= 1'b0;
                  state      <= S_DONE;
               end else if (!alu_carry_out) begin
                  addr_hi    <= base_q[15:8];
                  page_cross <= 1'b0;
                  state      <= S_DONE;
               end else begin
                  page_cross <= 1'b1;
                  state      <= S_HI;
               end
            end
            S_HI: begin
               addr_hi <= alu_Y;
               state   <= S_DONE;
            end
            S_DONE: begin
               if (resp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready       = (state == S_IDLE);
   assign resp_valid      = (state == S_DONE);
   assign resp_addr       = {addr_hi, addr_lo};
   assign resp_page_cross = page_cross;
   assign alu_busy        = (state == S_LO) || (state == S_HI);

   // idle defaults keep the ALU port quiet when the core mux selects us anyway
   always_comb begin
      alu_control  = ALU_ADD;
      alu_AI       = 8'h00;
      alu_BI       = 8'h00;
      alu_carry_in = 1'b0;
      case (state)
         S_LO: begin
            alu_AI = base_q[7:0];
            alu_BI = index_q;
         end
         S_HI: begin
            alu_AI       = base_q[15:8];
            alu_carry_in = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_addr_seq.sv
// Directed bench for addr_seq wired to the real alu; checks latency, results and handshakes.
module tb_addr_seq;
   import addr_seq_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_base;
   logic [7:0]  req_index;
   logic        req_zp;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_addr;
   logic        resp_page_cross;
   logic        alu_busy;
   logic [2:0]  alu_control;
   logic [7:0]  alu_AI;
   logic [7:0]  alu_BI;
   logic        alu_carry_in;
   logic [7:0]  alu_Y;
   logic        alu_carry_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   addr_seq dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_base(req_base), .req_index(req_index), .req_zp(req_zp),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_addr(resp_addr), .resp_page_cross(resp_page_cross),
      .alu_busy(alu_busy), .alu_control(alu_control),
      .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_carry_in(alu_carry_in),
      .alu_Y(alu_Y), .alu_carry_out(alu_carry_out)
   );

   alu u_alu (
      .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
      .alu_carry_in(alu_carry_in), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // advance one cycle; outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // present a request at a falling edge; returns at the falling edge of cycle 1
   task automatic issue(input logic [15:0] base, input logic [7:0] idx, input logic zp);
      req_valid = 1'b1;
      req_base  = base;
      req_index = idx;
      req_zp    = zp;
      tick();
      req_valid = 1'b0;
      req_base  = 16'hDEAD;
      req_index = 8'hBE;
      req_zp    = ~zp;
   endtask

   initial begin
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_base   = 16'h0000;
      req_index  = 8'h00;
      req_zp     = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      tick();
      chk("rst_req_ready", {15'd0, req_ready}, 16'd1);
      chk("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
      chk("rst_addr", resp_addr, 16'h0000);
      chk("rst_busy", {15'd0, alu_busy}, 16'd0);
      chk("rst_alu_ai", {8'd0, alu_AI}, 16'h0000);
      resetn = 1'b1;
      tick();

      // full mode, no page cross: 2-cycle latency
      issue(16'h1234, 8'h10, 1'b0);
      chk("t1_busy_c1", {15'd0, alu_busy}, 16'd1);
      chk("t1_ai_c1", {8'd0, alu_AI}, 16'h0034);
      chk("t1_bi_c1", {8'd0, alu_BI}, 16'h0010);
      chk("t1_ctl_c1", {13'd0, alu_control}, {13'd0, ALU_ADD});
      chk("t1_cin_c1", {15'd0, alu_carry_in}, 16'd0);
      chk("t1_valid_c1", {15'd0, resp_valid}, 16'd0);
      chk("t1_ready_c1", {15'd0, req_ready}, 16'd0);
      tick();
      chk("t1_valid_c2", {15'd0, resp_valid}, 16'd1);
      chk("t1_addr", resp_addr, 16'h1244);
      chk("t1_pc", {15'd0, resp_page_cross}, 16'd0);
      chk("t1_busy_c2", {15'd0, alu_busy}, 16'd0);
      tick();
      chk("t1_idle_valid", {15'd0, resp_valid}, 16'd0);
      chk("t1_idle_ready", {15'd0, req_ready}, 16'd1);

      // full mode, page cross: HI cycle, 3-cycle latency
      issue(16'h12F0, 8'h20, 1'b0);
      chk("t2_busy_c1", {15'd0, alu_busy}, 16'd1);
      tick();
      chk("t2_busy_c2", {15'd0, alu_busy}, 16'd1);
      chk("t2_ai_c2", {8'd0, alu_AI}, 16'h0012);
      chk("t2_bi_c2", {8'd0, alu_BI}, 16'h0000);
      chk("t2_cin_c2", {15'd0, alu_carry_in}, 16'd1);
      chk("t2_valid_c2", {15'd0, resp_valid}, 16'd0);
      tick();
      chk("t2_valid_c3", {15'd0, resp_valid}, 16'd1);
      chk("t2_busy_c3", {15'd0, alu_busy}, 16'd0);
      chk("t2_addr", resp_addr, 16'h1310);
      chk("t2_pc", {15'd0, resp_page_cross}, 16'd1);
      tick();

      // 0xFFFF + 1 wraps; carry out of the HI add is ignored
      issue(16'hFFFF, 8'h01, 1'b0);
      tick();
      chk("t3_hi_cout", {15'd0, alu_carry_out}, 16'd1);
      tick();
      chk("t3_valid", {15'd0, resp_valid}, 16'd1);
      chk("t3_addr", resp_addr, 16'h0000);
      chk("t3_pc", {15'd0, resp_page_cross}, 16'd1);
      tick();

      // zero-page: stays in page 0, no page cross, 2-cycle latency
      issue(16'h00F0, 8'h20, 1'b1);
      chk("t4_busy_c1", {15'd0, alu_busy}, 16'd1);
      tick();
      chk("t4_valid_c2", {15'd0, resp_valid}, 16'd1);
      chk("t4_addr", resp_addr, 16'h0010);
      chk("t4_pc", {15'd0, resp_page_cross}, 16'd0);
      tick();
      issue(16'h00FF, 8'h01, 1'b1);
      tick();
      chk("t4b_addr", resp_addr, 16'h0000);
      chk("t4b_pc", {15'd0, resp_page_cross}, 16'd0);
      tick();

      // back-pressure: DONE held for 5 cycles, request pulse ignored
      resp_ready = 1'b0;
      issue(16'h1234, 8'h10, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_valid", {15'd0, resp_valid}, 16'd1);
         chk("t5_hold_addr", resp_addr, 16'h1244);
         chk("t5_hold_ready", {15'd0, req_ready}, 16'd0);
         req_valid = (i == 2);
         req_base  = 16'hAAAA;
         tick();
      end
      req_valid = 1'b0;
      chk("t5_after_busy", {15'd0, alu_busy}, 16'd0);
      chk("t5_after_addr", resp_addr, 16'h1244);
      resp_ready = 1'b1;
      tick();
      chk("t5_rel_valid", {15'd0, resp_valid}, 16'd0);
      chk("t5_rel_ready", {15'd0, req_ready}, 16'd1);
      chk("t5_rel_busy", {15'd0, alu_busy}, 16'd0);
      tick();
      chk("t5_no_accept", {15'd0, alu_busy}, 16'd0);

      // reset during HI drops the request
      issue(16'h12F0, 8'h20, 1'b0);
      tick();
      chk("t6_in_hi", {15'd0, alu_busy}, 16'd1);
      resetn = 1'b0;
      tick();
      chk("t6_rst_ready", {15'd0, req_ready}, 16'd1);
      chk("t6_rst_valid", {15'd0, resp_valid}, 16'd0);
      chk("t6_rst_addr", resp_addr, 16'h0000);
      chk("t6_rst_pc", {15'd0, resp_page_cross}, 16'd0);
      chk("t6_rst_busy", {15'd0, alu_busy}, 16'd0);
      chk("t6_rst_ai", {8'd0, alu_AI}, 16'h0000);
      chk("t6_rst_cin", {15'd0, alu_carry_in}, 16'd0);
      resetn = 1'b1;
      issue(16'h0001, 8'h01, 1'b0);
      tick();
      chk("t6_post_valid", {15'd0, resp_valid}, 16'd1);
      chk("t6_post_addr", resp_addr, 16'h0002);
      chk("t6_post_pc", {15'd0, resp_page_cross}, 16'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
